// File: rtl/apa102_frame_decoder.sv
// APA102 strand receiver: oversamples sck/mosi with clk and decodes the start,
// LED and end frames into per-LED words with framing-error and stall reporting.
module apa102_frame_decoder #(
   parameter int unsigned MAX_LEDS = 16,
   parameter int unsigned NUM_LEDS = 0,
   parameter int unsigned TIMEOUT  = 4096
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            sck_in,
   input  logic                            mosi_in,
   output logic                            led_valid,
   output logic [$clog2(MAX_LEDS)-1:0]     led_index,
   output logic [4:0]                      led_brightness,
   output logic [7:0]                      led_blue,
   output logic [7:0]                      led_green,
   output logic [7:0]                      led_red,
   output logic                            frame_done,
   output logic [$clog2(MAX_LEDS+1)-1:0]   led_count,
   output logic                            hdr_error,
   output logic                            timeout,
   output logic                            overflow,
   output logic                            busy
);

   localparam int unsigned IDX_W = $clog2(MAX_LEDS);
   localparam int unsigned CNT_W = $clog2(MAX_LEDS + 1);
   localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {HUNT, SYNC, WORD, IDLEGAP} state_t;

   state_t            state;
   logic [2:0]        sck_sync;
   logic [1:0]        mosi_sync;
   logic [31:0]       shreg;
   logic [4:0]        zrun;
   logic [4:0]        bcnt;
   logic [CNT_W-1:0]  idx;
   logic [TO_W-1:0]   tcnt;
   logic              fall;
   logic              bit_in;
   logic [31:0]       next_word;

   // Two-flop synchronizers; the third sck flop gives the previous synced level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sck_sync  <= '0;
         mosi_sync <= '0;
      end else begin
         sck_sync  <= {sck_sync[1:0], sck_in};
         mosi_sync <= {mosi_sync[0], mosi_in};
      end
   end

   // Falling edge of synced sck is mid-bit, since mosi moves on the rising edge.
   assign fall      = sck_sync[2] & ~sck_sync[1];
   assign bit_in    = mosi_sync[1];
   assign next_word = {shreg[30:0], bit_in};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= HUNT;
         shreg          <= '0;
         zrun           <= '0;
         bcnt           <= '0;
         idx            <= '0;
         tcnt           <= '0;
         led_valid      <= 1'b0;
         led_index      <= '0;
         led_brightness <= '0;
         led_blue       <= '0;
         led_green      <= '0;
         led_red        <= '0;
         frame_done     <= 1'b0;
         led_count      <= '0;
         hdr_error      <= 1'b0;
         timeout        <= 1'b0;
         overflow       <= 1'b0;
         busy           <= 1'b0;
      end else begin
         led_valid  <= 1'b0;
         frame_done <= 1'b0;
         hdr_error  <= 1'b0;
         timeout    <= 1'b0;

         case (state)
            HUNT: begin
               if (fall) begin
                  if (bit_in) begin
                     zrun <= '0;
                  end else if (zrun == 5'd31) begin
                     zrun  <= '0;
                     idx   <= '0;
                     state <= SYNC;
                  end else begin
                     zrun <= zrun + 5'd1;
                  end
               end
            end

            SYNC: begin
               if (fall && bit_in) begin
                  shreg <= next_word;
                  bcnt  <= 5'd1;
                  tcnt  <= '0;
                  busy  <= 1'b1;
                  state <= WORD;
               end
            end

            WORD: begin
               if (fall) begin
                  tcnt  <= '0;
                  shreg <= next_word;
                  if (bcnt != 5'd31) begin
                     bcnt <= bcnt + 5'd1;
                  end else begin
                     bcnt <= '0;
                     if (NUM_LEDS != 0 && idx == CNT_W'(NUM_LEDS)) begin
                        // Fixed mode: the slot after the last LED must be the end frame.
                        if (next_word == '1) begin
                           frame_done <= 1'b1;
                           led_count  <= idx;
                        end else begin
                           hdr_error <= 1'b1;
                        end
                        busy  <= 1'b0;
                        state <= HUNT;
                     end else if (NUM_LEDS == 0 && next_word == '1) begin
                        frame_done <= 1'b1;
                        led_count  <= idx;
                        busy       <= 1'b0;
                        state      <= HUNT;
                     end else if (next_word[31:29] != 3'b111) begin
                        hdr_error <= 1'b1;
                        busy      <= 1'b0;
                        state     <= HUNT;
                     end else begin
                        if (idx < CNT_W'(MAX_LEDS)) begin
                           led_valid      <= 1'b1;
                           led_index      <= IDX_W'(idx);
                           led_brightness <= next_word[28:24];
                           led_blue       <= next_word[23:16];
                           led_green      <= next_word[15:8];
                           led_red        <= next_word[7:0];
                           idx            <= idx + CNT_W'(1);
                        end else begin
                           overflow <= 1'b1;
                        end
                        state <= IDLEGAP;
                     end
                  end
               end else if (tcnt == TO_W'(TIMEOUT - 1)) begin
                  timeout <= 1'b1;
                  bcnt    <= '0;
                  busy    <= 1'b0;
                  state   <= HUNT;
               end else begin
                  tcnt <= tcnt + TO_W'(1);
               end
            end

            IDLEGAP: begin
               // Whatever bit follows an LED word is the first bit of the next word.
               if (fall) begin
                  tcnt  <= '0;
                  shreg <= next_word;
                  bcnt  <= 5'd1;
                  state <= WORD;
               end else if (tcnt == TO_W'(TIMEOUT - 1)) begin
                  timeout <= 1'b1;
                  busy    <= 1'b0;
                  state   <= HUNT;
               end else begin
                  tcnt <= tcnt + TO_W'(1);
               end
            end

            default: begin
               busy  <= 1'b0;
               state <= HUNT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apa102_frame_decoder.sv
// Scoreboard bench: an auto-mode decoder (MAX_LEDS=4) and a fixed-mode decoder
// (NUM_LEDS=2) on separate strands; stimulus queues expected events, a monitor pops them.
`timescale 1ns/1ps
module tb_apa102_frame_decoder;

   localparam int unsigned TO = 200;
   localparam logic [1:0] K_LED = 2'd0, K_DONE = 2'd1, K_HDR = 2'd2, K_TO = 2'd3;

   typedef struct packed {
      logic [1:0] kind;
      logic [1:0] idx;
      logic [4:0] b;
      logic [7:0] bl;
      logic [7:0] g;
      logic [7:0] r;
      logic [2:0] cnt;
   } ev_t;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] sck   = 2'b00;
   logic [1:0] mosi  = 2'b00;
   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         last_fall = 0;
   ev_t        q_a[$];
   ev_t        q_f[$];

   logic       a_led_valid, a_frame_done, a_hdr_error, a_timeout, a_overflow, a_busy;
   logic [1:0] a_led_index;
   logic [4:0] a_led_brightness;
   logic [7:0] a_led_blue, a_led_green, a_led_red;
   logic [2:0] a_led_count;
   logic       f_led_valid, f_frame_done, f_hdr_error, f_timeout, f_overflow, f_busy;
   logic [1:0] f_led_index;
   logic [4:0] f_led_brightness;
   logic [7:0] f_led_blue, f_led_green, f_led_red;
   logic [2:0] f_led_count;

   apa102_frame_decoder #(.MAX_LEDS(4), .NUM_LEDS(0), .TIMEOUT(TO)) dut_a (
      .clk(clk), .reset(reset), .sck_in(sck[0]), .mosi_in(mosi[0]),
      .led_valid(a_led_valid), .led_index(a_led_index), .led_brightness(a_led_brightness),
      .led_blue(a_led_blue), .led_green(a_led_green), .led_red(a_led_red),
      .frame_done(a_frame_done), .led_count(a_led_count), .hdr_error(a_hdr_error),
      .timeout(a_timeout), .overflow(a_overflow), .busy(a_busy));

   apa102_frame_decoder #(.MAX_LEDS(4), .NUM_LEDS(2), .TIMEOUT(TO)) dut_f (
      .clk(clk), .reset(reset), .sck_in(sck[1]), .mosi_in(mosi[1]),
      .led_valid(f_led_valid), .led_index(f_led_index), .led_brightness(f_led_brightness),
      .led_blue(f_led_blue), .led_green(f_led_green), .led_red(f_led_red),
      .frame_done(f_frame_done), .led_count(f_led_count), .hdr_error(f_hdr_error),
      .timeout(f_timeout), .overflow(f_overflow), .busy(f_busy));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic ev_t mk(input logic [1:0] k, input logic [1:0] i, input logic [4:0] b,
                              input logic [7:0] bl, input logic [7:0] g, input logic [7:0] r,
                              input logic [2:0] c);
      mk = {k, i, b, bl, g, r, c};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, got, exp);
      end
   endtask

   task automatic sb_check(input int s, input ev_t got, input string name);
      ev_t e;
      int  d;
      n_cmp++;
      if ((s == 0 && q_a.size() == 0) || (s == 1 && q_f.size() == 0)) begin
         n_err++;
         $display("FAIL %s: unexpected event got %h, required none", name, got);
      end else begin
         if (s == 0) e = q_a.pop_front();
         else        e = q_f.pop_front();
         if (got !== e) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, got, e);
         end
      end
      if (got.kind == K_TO) begin
         // Two sync flops plus the edge flop put detection 3 clks after the drive.
         d = cyc - last_fall;
         n_cmp++;
         if (d < int'(TO) + 2 || d > int'(TO) + 4) begin
            n_err++;
            $display("FAIL timeout_latency: got %0d clks, required %0d..%0d", d, TO + 2, TO + 4);
         end
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (a_led_valid)  sb_check(0, mk(K_LED, a_led_index, a_led_brightness, a_led_blue, a_led_green, a_led_red, 3'd0), "a_led");
         if (a_frame_done) sb_check(0, mk(K_DONE, 2'd0, 5'd0, 8'd0, 8'd0, 8'd0, a_led_count), "a_done");
         if (a_hdr_error)  sb_check(0, mk(K_HDR, 2'd0, 5'd0, 8'd0, 8'd0, 8'd0, 3'd0), "a_hdr");
         if (a_timeout)    sb_check(0, mk(K_TO, 2'd0, 5'd0, 8'd0, 8'd0, 8'd0, 3'd0), "a_timeout");
         if (f_led_valid)  sb_check(1, mk(K_LED, f_led_index, f_led_brightness, f_led_blue, f_led_green, f_led_red, 3'd0), "f_led");
         if (f_frame_done) sb_check(1, mk(K_DONE, 2'd0, 5'd0, 8'd0, 8'd0, 8'd0, f_led_count), "f_done");
         if (f_hdr_error)  sb_check(1, mk(K_HDR, 2'd0, 5'd0, 8'd0, 8'd0, 8'd0, 3'd0), "f_hdr");
         if (f_timeout)    sb_check(1, mk(K_TO, 2'd0, 5'd0, 8'd0, 8'd0, 8'd0, 3'd0), "f_timeout");
      end
   end

   // One strand bit: mosi changes with the rising sck, sampled on the falling sck.
   task automatic bit_tx(input int s, input logic b);
      @(posedge clk); #1;
      sck[s]  = 1'b1;
      mosi[s] = b;
      repeat (4) @(posedge clk);
      #1;
      sck[s]    = 1'b0;
      last_fall = cyc;
      repeat (4) @(posedge clk);
   endtask

   task automatic word_tx(input int s, input logic [31:0] w);
      for (int i = 31; i >= 0; i--) bit_tx(s, w[i]);
   endtask

   task automatic zeros_tx(input int s, input int n);
      for (int i = 0; i < n; i++) bit_tx(s, 1'b0);
   endtask

   task automatic exp_led(input int s, input logic [1:0] i, input logic [4:0] b,
                          input logic [7:0] bl, input logic [7:0] g, input logic [7:0] r);
      if (s == 0) q_a.push_back(mk(K_LED, i, b, bl, g, r, 3'd0));
      else        q_f.push_back(mk(K_LED, i, b, bl, g, r, 3'd0));
   endtask

   task automatic exp_evt(input int s, input logic [1:0] k, input logic [2:0] c);
      if (s == 0) q_a.push_back(mk(k, 2'd0, 5'd0, 8'd0, 8'd0, 8'd0, c));
      else        q_f.push_back(mk(k, 2'd0, 5'd0, 8'd0, 8'd0, 8'd0, c));
   endtask

   logic [31:0] tmp;

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_flags_a", {26'd0, a_led_valid, a_frame_done, a_hdr_error, a_timeout, a_overflow, a_busy}, 32'd0);
      chk("rst_fields_a", {a_led_index, a_led_brightness, a_led_blue, a_led_green, a_led_red}, 32'd0);
      chk("rst_flags_f", {23'd0, f_led_count, f_led_valid, f_frame_done, f_hdr_error, f_timeout, f_overflow, f_busy}, 32'd0);
      reset = 1'b0;
      repeat (3) @(posedge clk);

      // Auto mode, three LEDs.
      exp_led(0, 2'd0, 5'd5,  8'hFF, 8'h00, 8'h00);
      exp_led(0, 2'd1, 5'd0,  8'h00, 8'h00, 8'h00);
      exp_led(0, 2'd2, 5'd31, 8'h00, 8'h00, 8'hFF);
      exp_evt(0, K_DONE, 3'd3);
      zeros_tx(0, 32);
      word_tx(0, 32'hE5FF0000);
      word_tx(0, 32'hE0000000);
      word_tx(0, 32'hFF0000FF);
      word_tx(0, 32'hFFFFFFFF);
      chk("busy_after_frame", {31'd0, a_busy}, 32'd0);

      // Fixed mode NUM_LEDS=2: first all-ones word is an LED.
      exp_led(1, 2'd0, 5'd31, 8'hFF, 8'hFF, 8'hFF);
      exp_led(1, 2'd1, 5'd1,  8'h01, 8'h02, 8'h03);
      exp_evt(1, K_DONE, 3'd2);
      zeros_tx(1, 32);
      word_tx(1, 32'hFFFFFFFF);
      word_tx(1, 32'hE1010203);
      word_tx(1, 32'hFFFFFFFF);

      // 31 zeros then a 1 is no start; then a bad header. 60000000 is shifted by
      // the ignored leading zero, so one padding zero completes it as C0000000.
      exp_evt(0, K_HDR, 3'd0);
      zeros_tx(0, 31);
      bit_tx(0, 1'b1);
      zeros_tx(0, 32);
      word_tx(0, 32'h60000000);
      bit_tx(0, 1'b0);
      exp_led(0, 2'd0, 5'd1, 8'h01, 8'h02, 8'h03);
      exp_evt(0, K_DONE, 3'd1);
      zeros_tx(0, 32);
      word_tx(0, 32'hE1010203);
      word_tx(0, 32'hFFFFFFFF);
      chk("overflow_before", {31'd0, a_overflow}, 32'd0);

      // Five LEDs into four slots.
      for (int i = 0; i < 4; i++) exp_led(0, 2'(i), 5'd3, 8'h11, 8'h22, 8'h33);
      exp_evt(0, K_DONE, 3'd4);
      zeros_tx(0, 32);
      for (int i = 0; i < 5; i++) word_tx(0, 32'hE3112233);
      chk("overflow_set", {31'd0, a_overflow}, 32'd1);
      word_tx(0, 32'hFFFFFFFF);
      chk("overflow_sticky", {31'd0, a_overflow}, 32'd1);

      // Stall after 10 bits of an LED word.
      zeros_tx(0, 32);
      tmp = 32'hE3112233;
      for (int i = 31; i >= 22; i--) bit_tx(0, tmp[i]);
      chk("busy_mid_word", {31'd0, a_busy}, 32'd1);
      exp_evt(0, K_TO, 3'd0);
      repeat (TO + 20) @(posedge clk);
      @(negedge clk);
      chk("busy_after_timeout", {31'd0, a_busy}, 32'd0);
      chk("overflow_after_timeout", {31'd0, a_overflow}, 32'd1);

      // Reset mid-word, then resume the old stream with no start frame.
      zeros_tx(0, 32);
      for (int i = 31; i >= 20; i--) bit_tx(0, tmp[i]);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("midreset_flags_a", {26'd0, a_led_valid, a_frame_done, a_hdr_error, a_timeout, a_overflow, a_busy}, 32'd0);
      chk("midreset_fields_a", {a_led_index, a_led_brightness, a_led_blue, a_led_green, a_led_red}, 32'd0);
      chk("midreset_count_a", {29'd0, a_led_count}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 19; i >= 0; i--) bit_tx(0, tmp[i]);
      word_tx(0, 32'hE3112233);
      word_tx(0, 32'hFFFFFFFF);

      repeat (50) @(posedge clk);
      @(negedge clk);
      chk("queue_a_drained", q_a.size(), 32'd0);
      chk("queue_f_drained", q_f.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
